// File: rtl/i2s_tx_ctrl.sv
// I2S transmit controller: derives mclk/sclk/lrclk from clk, buffers one
// stereo sample pair behind a valid/ready handshake and shifts it out
// MSB-first in Philips I2S format, flagging frames that start with no sample.
module i2s_tx_ctrl #(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned SLOT_W   = 32,
  parameter int unsigned SCLK_DIV = 16,
  parameter int unsigned MCLK_DIV = 4
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              enable,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              s_ready,
  output logic              underrun,
  output logic              busy,
  output logic              i2s_mclk,
  output logic              i2s_sclk,
  output logic              i2s_lrclk,
  output logic              i2s_sdata
);

  localparam int unsigned DIV_W = $clog2(SCLK_DIV);
  localparam int unsigned BIT_W = $clog2(2 * SLOT_W);
  localparam int unsigned MCK_W = $clog2(MCLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(SCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0] SLOT      = BIT_W'(SLOT_W);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W);
  localparam logic [MCK_W-1:0] MCK_LAST  = MCK_W'(MCLK_DIV - 1);
  localparam logic [MCK_W-1:0] MCK_HALF  = MCK_W'(MCLK_DIV / 2);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } state_t;

  state_t              state, state_n;
  logic [DIV_W-1:0]    div_cnt, div_n, div_adv;
  logic [BIT_W-1:0]    bit_cnt, bit_n, bit_adv;
  logic [MCK_W-1:0]    mclk_cnt, mclk_n, mclk_adv;
  logic [BIT_W-1:0]    pos_n;
  logic                tick, boundary, load, shift;
  logic                xfer, hold_full, full_n;
  logic [2*DATA_W-1:0] hold, shreg;

  // Next-state, counter advance and frame-boundary load decisions
  always_comb begin
    state_n  = state;
    tick     = (div_cnt == DIV_LAST);
    boundary = tick && (bit_cnt == BIT_LAST);
    load     = 1'b0;
    div_adv  = tick ? '0 : div_cnt + 1'b1;
    bit_adv  = tick ? ((bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1) : bit_cnt;
    mclk_adv = (mclk_cnt == MCK_LAST) ? '0 : mclk_cnt + 1'b1;
    div_n    = div_cnt;
    bit_n    = bit_cnt;
    mclk_n   = mclk_cnt;
    case (state)
      IDLE: begin
        div_n  = '0;
        bit_n  = '0;
        mclk_n = '0;
        if (enable) begin
          state_n = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        div_n  = div_adv;
        bit_n  = bit_adv;
        mclk_n = mclk_adv;
        load   = boundary;
        if (!enable) state_n = STOP;
      end
      STOP: begin
        div_n  = div_adv;
        bit_n  = bit_adv;
        mclk_n = mclk_adv;
        if (enable) begin
          state_n = RUN;
          load    = boundary;
        end else if (boundary) begin
          state_n = IDLE;
          div_n   = '0;
          bit_n   = '0;
          mclk_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase
    pos_n  = (bit_n >= SLOT) ? bit_n - SLOT : bit_n;
    // Data bits occupy slot positions 1..DATA_W; position 0 is the I2S delay bit
    shift  = tick && (state != IDLE) && (state_n != IDLE) &&
             (pos_n != '0) && (pos_n <= DATA_LAST);
    xfer   = s_valid && s_ready;
    full_n = (hold_full && !load) || xfer;
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (arst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      mclk_cnt <= '0;
    end else begin
      state    <= state_n;
      div_cnt  <= div_n;
      bit_cnt  <= bit_n;
      mclk_cnt <= mclk_n;
    end
  end

  // One-entry holding register; a transfer during a load refills it for the next frame
  always_ff @(posedge clk) begin
    if (arst) begin
      hold_full <= 1'b0;
      s_ready   <= 1'b0;
      hold      <= '0;
    end else begin
      hold_full <= full_n;
      s_ready   <= !full_n;
      if (xfer) hold <= {s_left, s_right};
    end
  end

  // Frame shift register: left sample in the upper half shifts out first
  always_ff @(posedge clk) begin
    if (arst) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= hold_full ? hold : '0;
    end else if (shift) begin
      shreg <= {shreg[2*DATA_W-2:0], 1'b0};
    end
  end

  // Registered pin and status outputs, computed from the post-edge counter values
  always_ff @(posedge clk) begin
    if (arst) begin
      underrun  <= 1'b0;
      busy      <= 1'b0;
      i2s_mclk  <= 1'b0;
      i2s_sclk  <= 1'b0;
      i2s_lrclk <= 1'b0;
      i2s_sdata <= 1'b0;
    end else begin
      underrun <= load && !hold_full;
      busy     <= (state_n != IDLE);
      if (state_n == IDLE) begin
        i2s_mclk  <= 1'b0;
        i2s_sclk  <= 1'b0;
        i2s_lrclk <= 1'b0;
        i2s_sdata <= 1'b0;
      end else begin
        i2s_mclk  <= (mclk_n >= MCK_HALF);
        i2s_sclk  <= (div_n >= DIV_HALF);
        i2s_lrclk <= (bit_n >= SLOT);
        if (shift)             i2s_sdata <= shreg[2*DATA_W-1];
        else if (tick || load) i2s_sdata <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// Bench for i2s_tx_ctrl: cycle-level reference model derived from elapsed
// time since stream start, plus directed scenarios with literal expectations.
module tb_i2s_tx_ctrl;

  localparam int DATA_W   = 24;
  localparam int SLOT_W   = 32;
  localparam int SCLK_DIV = 16;
  localparam int MCLK_DIV = 4;
  localparam int FR       = 2 * SLOT_W * SCLK_DIV;

  logic              clk = 1'b0;
  logic              arst = 1'b1;
  logic              enable = 1'b0;
  logic              s_valid = 1'b0;
  logic [DATA_W-1:0] s_left = '0;
  logic [DATA_W-1:0] s_right = '0;
  logic              s_ready, underrun, busy;
  logic              i2s_mclk, i2s_sclk, i2s_lrclk, i2s_sdata;
  logic [6:0]        outv;

  i2s_tx_ctrl #(
    .DATA_W  (DATA_W),
    .SLOT_W  (SLOT_W),
    .SCLK_DIV(SCLK_DIV),
    .MCLK_DIV(MCLK_DIV)
  ) dut (
    .clk      (clk),
    .arst     (arst),
    .enable   (enable),
    .s_valid  (s_valid),
    .s_left   (s_left),
    .s_right  (s_right),
    .s_ready  (s_ready),
    .underrun (underrun),
    .busy     (busy),
    .i2s_mclk (i2s_mclk),
    .i2s_sclk (i2s_sclk),
    .i2s_lrclk(i2s_lrclk),
    .i2s_sdata(i2s_sdata)
  );

  always #5 clk = ~clk;

  assign outv = {s_ready, underrun, busy, i2s_mclk, i2s_sclk, i2s_lrclk, i2s_sdata};

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 streaming, 2 draining; t counts clk cycles since stream start
  int                m_ph = 0;
  int                m_t = 0;
  logic              m_full = 1'b0;
  logic              m_ready = 1'b0;
  logic              m_ur = 1'b0;
  logic              m_ld, m_xfer;
  logic [DATA_W-1:0] m_hl = '0, m_hr = '0, m_fl = '0, m_fr = '0;

  always @(posedge clk) begin
    cyc++;
    if (arst) begin
      m_ph = 0; m_t = 0; m_full = 1'b0; m_ready = 1'b0; m_ur = 1'b0;
      m_hl = '0; m_hr = '0; m_fl = '0; m_fr = '0;
    end else begin
      m_ld   = 1'b0;
      m_xfer = s_valid && m_ready;
      case (m_ph)
        0: if (enable) begin m_ph = 1; m_t = 0; m_ld = 1'b1; end
        1: begin
          m_t++;
          m_ld = (m_t % FR == 0);
          if (!enable) m_ph = 2;
        end
        default: begin
          m_t++;
          if (enable) begin m_ph = 1; m_ld = (m_t % FR == 0); end
          else if (m_t % FR == 0) m_ph = 0;
        end
      endcase
      m_ur = m_ld && !m_full;
      if (m_ld) begin
        m_fl = m_full ? m_hl : '0;
        m_fr = m_full ? m_hr : '0;
        m_full = 1'b0;
      end
      if (m_xfer) begin m_hl = s_left; m_hr = s_right; m_full = 1'b1; end
      m_ready = !m_full;
    end
  end

  function automatic logic [6:0] model_out();
    int tt, dv, b, p;
    logic lr, sd, mk, sk;
    logic [DATA_W-1:0] smp;
    if (m_ph == 0) return {m_ready, m_ur, 5'b0};
    tt  = m_t % FR;
    dv  = tt % SCLK_DIV;
    b   = tt / SCLK_DIV;
    lr  = (b >= SLOT_W);
    p   = b % SLOT_W;
    smp = lr ? m_fr : m_fl;
    sd  = (p >= 1 && p <= DATA_W) ? smp[DATA_W-p] : 1'b0;
    mk  = ((m_t % MCLK_DIV) >= MCLK_DIV / 2);
    sk  = (dv >= SCLK_DIV / 2);
    return {m_ready, m_ur, 1'b1, mk, sk, lr, sd};
  endfunction

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (cyc > 0) begin
      checks++;
      if (outv !== model_out()) begin
        errors++;
        $display("FAIL model_cycle cyc=%0d: dut=%b model=%b", cyc, outv, model_out());
      end
    end
  end

  // ---------------- observation monitor ----------------
  bit bitq[$];
  logic p_sclk = 1'b0, p_lr = 1'b0, p_mclk = 1'b0;
  int sclk_last = 0, lr_last = 0, mclk_last = 0;
  int sclk_per = 0, lr_per = 0, mclk_per = 0;

  // Capture sdata at each sclk rise and measure clock periods
  always @(negedge clk) begin
    if (i2s_sclk && !p_sclk) begin
      bitq.push_back(i2s_sdata);
      sclk_per = cyc - sclk_last; sclk_last = cyc;
    end
    if (i2s_lrclk && !p_lr) begin lr_per = cyc - lr_last; lr_last = cyc; end
    if (i2s_mclk && !p_mclk) begin mclk_per = cyc - mclk_last; mclk_last = cyc; end
    p_sclk = i2s_sclk; p_lr = i2s_lrclk; p_mclk = i2s_mclk;
  end

  function automatic logic [DATA_W-1:0] take(input int start);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < DATA_W; i++) v = {v[DATA_W-2:0], logic'(bitq[start+i])};
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    arst = 1'b1; enable = 1'b0; s_valid = 1'b0;
    repeat (3) step();
    check("reset_outputs_zero", 64'(outv), 64'(0));
    arst = 1'b0;
    step();
    check("post_reset_ready_idle", 64'(outv), 64'(7'b1000000));
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 1100 && busy; i++) step();
    check(name, 64'(busy), 64'(0));
  endtask

  logic [DATA_W-1:0] bp_base, bp_k;
  logic              bp_prev;
  int                xq[$];

  task automatic bp_step();
    step();
    if (bp_prev) begin
      bp_k    = bp_k + 1'b1;
      s_left  = bp_base + bp_k;
      s_right = (bp_base + bp_k) ^ 24'h5A5A5A;
    end
    bp_prev = s_valid && s_ready;
    if (bp_prev) xq.push_back(cyc);
  endtask

  int entry;
  int urq[$];
  logic sd_or;
  logic [63:0] got, want;

  initial begin
    // Reset behaviour
    do_reset();

    // Single frame with known sample, then an underrun frame
    bitq.delete();
    s_left = 24'hABCDEF; s_right = 24'h123456; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    check("ready_low_after_write", 64'(s_ready), 64'(0));
    enable = 1'b1;
    step();
    entry = cyc;
    check("entry_busy_sclk_lr", 64'({busy, i2s_sclk, i2s_lrclk, underrun}), 64'(4'b1000));
    while (cyc - entry < 7) step();
    check("sclk_low_before_half", 64'(i2s_sclk), 64'(0));
    step();
    check("first_sclk_rise", 64'(i2s_sclk), 64'(1));
    while (cyc - entry < 15) step();
    check("delay_bit_zero", 64'(i2s_sdata), 64'(0));
    step();
    check("left_msb_at_sclk_div", 64'(i2s_sdata), 64'(1));
    for (int i = 0; i < 1200 && bitq.size() < 64; i++) step();
    check("frame_bits_captured", 64'(bitq.size() >= 64), 64'(1));
    for (int i = 0; i < 64; i++) got[63-i] = bitq[i];
    want = {1'b0, 24'hABCDEF, 7'b0, 1'b0, 24'h123456, 7'b0};
    check("frame_serial_pattern", got, want);
    while (cyc - entry < 2100) step();
    check("lrclk_period", 64'(lr_per), 64'(FR));
    check("sclk_period", 64'(sclk_per), 64'(SCLK_DIV));
    check("mclk_period", 64'(mclk_per), 64'(MCLK_DIV));
    enable = 1'b0;
    wait_idle("single_frame_idle");

    // Underrun stream
    do_reset();
    urq.delete(); sd_or = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 3100; i++) begin
      step();
      if (underrun) urq.push_back(i);
      sd_or = sd_or | i2s_sdata;
    end
    check("underrun_count", 64'(urq.size()), 64'(4));
    check("underrun_at_entry", 64'(urq[0]), 64'(0));
    check("underrun_spacing", 64'(urq[2] - urq[1]), 64'(FR));
    check("underrun_sdata_quiet", 64'(sd_or), 64'(0));
    enable = 1'b0;
    wait_idle("underrun_idle");

    // Back-pressure stream followed by a drain at left bit 10
    do_reset();
    bitq.delete(); xq.delete();
    bp_base = DATA_W'($urandom);
    bp_k    = '0;
    s_left  = bp_base; s_right = bp_base ^ 24'h5A5A5A; s_valid = 1'b1;
    bp_prev = s_ready;
    if (bp_prev) xq.push_back(cyc);
    repeat (4) bp_step();
    enable = 1'b1;
    bp_step();
    entry = cyc;
    while (cyc - entry < 3 * FR + 10 * SCLK_DIV + 2) bp_step();
    enable = 1'b0;
    while (cyc - entry < 4 * FR - 1) bp_step();
    check("drain_busy_before_boundary", 64'(busy), 64'(1));
    bp_step();
    check("drain_idle_outputs", 64'(outv), 64'(0));
    repeat (3) bp_step();
    check("drain_hold_retained", 64'(s_ready), 64'(0));
    check("bp_transfer_count", 64'(xq.size()), 64'(5));
    check("bp_second_at_entry", 64'(xq[1]), 64'(entry));
    check("bp_spacing", 64'(xq[4] - xq[3]), 64'(FR));
    check("bp_bits_captured", 64'(bitq.size()), 64'(4 * 64));
    for (int f = 0; f < 4; f++) begin
      check("bp_left_seq", 64'(take(64 * f + 1)), 64'(DATA_W'(bp_base + DATA_W'(f))));
      check("bp_right_seq", 64'(take(64 * f + 33)),
            64'(DATA_W'(bp_base + DATA_W'(f)) ^ 24'h5A5A5A));
    end

    // Mid-frame reset during the right slot
    s_valid = 1'b0;
    enable = 1'b1;
    step();
    entry = cyc;
    while (cyc - entry < 700) step();
    check("midreset_in_right_slot", 64'(i2s_lrclk), 64'(1));
    arst = 1'b1;
    step();
    check("midreset_outputs_zero", 64'(outv), 64'(0));
    arst = 1'b0; enable = 1'b0;
    step();
    check("midreset_release_empty_idle", 64'(outv), 64'(7'b1000000));

    // Randomised traffic with occasional enable toggles
    enable = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      step();
      s_valid = ($urandom_range(0, 3) == 0);
      s_left  = DATA_W'($urandom);
      s_right = DATA_W'($urandom);
      if ($urandom_range(0, 999) == 0) enable = !enable;
    end
    enable = 1'b0; s_valid = 1'b0;
    wait_idle("random_final_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
